arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of each channel's burst-length field.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles a channel waits for grant when ARB_REQ_TIMEOUT_EN is defined.
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 Port rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port job_valid  in  2  SHALL carry the per-channel job offer; bit i = channel i.
REQ-006 Port job_ready  out  2  SHALL indicate the per-channel job acceptance.
REQ-007 Port job_len  in  2*LEN_W  SHALL carry the per-channel beat count; channel i uses bits [i*LEN_W +: LEN_W].
REQ-008 Port request  out  2  SHALL drive the arbiter request vector; bit1 is the high-priority channel.
REQ-009 Port grant  in  2  SHALL receive the arbiter grant vector (registered, 00/01/10).
REQ-010 Port beat  out  2  SHALL pulse for one cycle per transferred beat, per channel.
REQ-011 Port done  out  2  SHALL pulse for one cycle on a channel's final beat.
REQ-012 Port timeout_err  out  2  SHALL pulse for one cycle on a channel's grant-wait timeout.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, REQ, XFER, REL.
REQ-014 In IDLE, job_ready[i] SHALL be 1; a handshake (job_valid[i] & job_ready[i]) SHALL latch len = job_len slice and move the FSM to REQ.
REQ-015 A latched length of 0 SHALL be treated as 1 beat.
REQ-016 request[i] SHALL be a registered output, 1 exactly while the FSM is in REQ or XFER.
REQ-017 In REQ, if grant == (1<<i), the FSM SHALL move to XFER, and that cycle SHALL count as beat 1 (beat[i]=1).
REQ-018 In XFER, every cycle with grant == (1<<i) SHALL pulse beat[i] and decrement the remaining count.
REQ-019 In XFER, a cycle without grant (preemption by channel 1) SHALL stall: no beat, count held, request held.
REQ-020 On the final beat, done[i] SHALL pulse in the same cycle as beat[i], and the FSM SHALL move to REL.
REQ-021 REL SHALL last exactly 1 cycle with request[i]=0 and job_ready[i]=0, then return to IDLE.
REQ-022 Grant SHALL be ignored in IDLE and REL, because arbiter grant lags request by 1 cycle.
REQ-023 Minimum job turnaround, offer to next job_ready, SHALL be len + 3 cycles under uncontended grant.
REQ-024 Both channels accepting jobs in the same cycle SHALL both enter REQ; channel 1 SHALL complete first per arbiter priority.

Reset
REQ-025 A cycle with rst=1 SHALL force both FSMs to IDLE and clear all counters.
REQ-026 During that cycle, request, beat, done and timeout_err SHALL be 2'b00.
REQ-027 While rst=1, job_ready SHALL be 2'b00.
REQ-028 Reset asserted mid-XFER SHALL abort the job without a done pulse.
REQ-029 After reset releases, request SHALL be 0 on the first cycle.

Configuration
REQ-030 With ARB_REQ_TIMEOUT_EN defined, a per-channel counter SHALL count consecutive REQ cycles without grant, cleared on grant.
REQ-031 When that counter reaches TIMEOUT, timeout_err[i] SHALL pulse and the FSM SHALL go to REL, with no done pulse.
REQ-032 Without ARB_REQ_TIMEOUT_EN, REQ SHALL wait indefinitely, timeout_err SHALL be tied to 2'b00, and no timeout counter SHALL exist.

Verification
REQ-033 Reset: rst=1 for 2 cycles with job_valid=11 -> job_ready=00 and request=00; job_ready=11 on the first cycle after release.
REQ-034 Single job: ch0 job_len=3, grant follows request -> request=01, 3 beat[0] pulses, done[0] on the 3rd, request=00 next cycle, job_ready[0]=1 two cycles later.
REQ-035 Contention: both channels offer len=2 in the same cycle -> ch1 finishes first (2 beats), then ch0 gets grant and finishes 2 beats; the two channels' beats never pulse in the same cycle.
REQ-036 Preemption: ch0 in XFER len=4 after 1 beat, ch1 requests -> ch0 stalls while grant=10; ch0 delivers the remaining 3 beats after ch1 is done.
REQ-037 Zero length: job_len=0 on ch1 -> exactly 1 beat and done pulse.
REQ-038 Timeout (macro on, TIMEOUT=16): grant held at 00 -> timeout_err[0] pulses after 16 REQ cycles, request[0] drops, and no done pulse occurs; with the macro off, request stays high.

Source files
------------

// File: rtl/arb_requester.sv
// Two-channel burst requester in front of a registered fixed-priority arbiter (ch1 wins).
// Optional grant-wait timeout: define ARB_REQ_TIMEOUT_EN.

module arb_req_chan #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int ID      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    input  logic [1:0]       grant,
    output logic             job_ready,
    output logic             request,
    output logic             beat,
    output logic             done,
    output logic             timeout_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] REL  = 2'd3;
    localparam logic [1:0] MY_GNT = 2'(1 << ID);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [1:0]       state, state_nxt;
    logic [LEN_W-1:0] remain;
    logic             req_q;
    logic             my_gnt, active, last, to_hit;

    // grant is only meaningful while we hold request; it lags by a cycle
    assign my_gnt    = (grant == MY_GNT);
    assign active    = (state == REQ) || (state == XFER);
    assign last      = (remain == LEN_W'(1));
    assign beat      = !rst && active && my_gnt;
    assign done      = beat && last;
    assign job_ready = !rst && (state == IDLE);
    assign request   = req_q && !rst;
    assign timeout_err = to_hit;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    assign to_hit = !rst && (state == REQ) && !my_gnt && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != REQ || my_gnt)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + TW'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (job_valid) state_nxt = REQ;
            REQ: begin
                if (my_gnt)      state_nxt = last ? REL : XFER;
                else if (to_hit) state_nxt = REL;
            end
            XFER: if (my_gnt && last) state_nxt = REL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            remain <= '0;
            req_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= (state_nxt == REQ) || (state_nxt == XFER);
            // zero-length jobs still move one beat
            if (state == IDLE && job_valid)
                remain <= (job_len == '0) ? LEN_W'(1) : job_len;
            else if (beat && !last)
                remain <= remain - LEN_W'(1);
        end
    end
endmodule

module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         job_valid,
    output logic [1:0]         job_ready,
    input  logic [2*LEN_W-1:0] job_len,
    output logic [1:0]         request,
    input  logic [1:0]         grant,
    output logic [1:0]         beat,
    output logic [1:0]         done,
    output logic [1:0]         timeout_err
);
    for (genvar i = 0; i < 2; i++) begin : g_chan
        arb_req_chan #(
            .LEN_W   (LEN_W),
            .TIMEOUT (TIMEOUT),
            .ID      (i)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .job_valid   (job_valid[i]),
            .job_len     (job_len[i*LEN_W +: LEN_W]),
            .grant       (grant),
            .job_ready   (job_ready[i]),
            .request     (request[i]),
            .beat        (beat[i]),
            .done        (done[i]),
            .timeout_err (timeout_err[i])
        );
    end
endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: a registered priority arbiter model drives grant,
// directed jobs push expected beats, a negedge monitor pops and compares.

module tb_arb_requester;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         job_valid = 2'b00;
    logic [2*LEN_W-1:0] job_len = '0;
    logic [1:0]         grant = 2'b00;
    logic               arb_off = 1'b0;
    logic [1:0]         job_ready, request, beat, done, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int beat_cnt[2];
    int done_cyc[2];
    int to_cnt[2];
    bit exp_q[2][$];

    arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_len     (job_len),
        .request     (request),
        .grant       (grant),
        .beat        (beat),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // registered fixed-priority arbiter, ch1 highest
    always @(posedge clk) begin
        if (rst || arb_off) grant <= 2'b00;
        else if (request[1]) grant <= 2'b10;
        else if (request[0]) grant <= 2'b01;
        else grant <= 2'b00;
    end

    always @(negedge clk) begin
        cyc++;
        if (beat === 2'b11) begin
            n_tests++; n_fail++;
            $display("FAIL beat_overlap: got beat=%b required one channel at a time", beat);
        end
        for (int i = 0; i < 2; i++) begin
            if (timeout_err[i]) to_cnt[i]++;
            if (beat[i]) begin
                beat_cnt[i]++;
                n_tests++;
                if (exp_q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat ch%0d: got beat with done=%b, required no beat", i, done[i]);
                end else begin
                    bit e;
                    e = exp_q[i].pop_front();
                    if (done[i] !== e) begin
                        n_fail++;
                        $display("FAIL beat_done ch%0d: got done=%b required %b", i, done[i], e);
                    end
                end
            end else if (done[i]) begin
                n_tests++; n_fail++;
                $display("FAIL done_without_beat ch%0d: got done=1 required 0", i);
            end
            if (done[i]) done_cyc[i] = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] m, input int l0, input int l1, input bit push);
        int l;
        job_len   = {LEN_W'(l1), LEN_W'(l0)};
        job_valid = m;
        for (int i = 0; i < 2; i++) begin
            if (m[i] && push) begin
                l = (i == 0) ? l0 : l1;
                if (l == 0) l = 1;
                for (int b = 1; b <= l; b++) exp_q[i].push_back(b == l);
            end
        end
        tick();
        job_valid = 2'b00;
    endtask

    task automatic wait_done(input int ch, input int bound);
        int k = 0;
        while (!done[ch] && k < bound) begin
            tick();
            k++;
        end
        check($sformatf("done_seen_ch%0d", ch), int'(done[ch]), 1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || job_ready != 2'b11) && k < bound) begin
            tick();
            k++;
        end
        check("return_to_idle", int'(job_ready), 3);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            beat_cnt[i] = 0;
            done_cyc[i] = 0;
            to_cnt[i]   = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_counts();
        // reset with offers pending
        rst = 1'b1;
        job_valid = 2'b11;
        tick();
        check("rst_job_ready_c1", int'(job_ready), 0);
        check("rst_request_c1", int'(request), 0);
        tick();
        check("rst_job_ready_c2", int'(job_ready), 0);
        check("rst_request_c2", int'(request), 0);
        check("rst_outputs_zero", int'({beat, done, timeout_err}), 0);
        rst = 1'b0;
        job_valid = 2'b00;
        tick();
        check("post_rst_job_ready", int'(job_ready), 3);
        check("post_rst_request", int'(request), 0);

        // single job on ch0, len 3
        clr_counts();
        offer(2'b01, 3, 0, 1'b1);
        check("single_request", int'(request), 1);
        wait_done(0, 20);
        check("single_beats", beat_cnt[0], 3);
        tick();
        check("single_rel_request", int'(request), 0);
        check("single_rel_ready", int'(job_ready[0]), 0);
        tick();
        check("single_ready_back", int'(job_ready[0]), 1);

        // contention, both len 2
        clr_counts();
        offer(2'b11, 2, 2, 1'b1);
        check("contend_request", int'(request), 3);
        wait_idle(40);
        check("contend_ch1_first", int'(done_cyc[1] < done_cyc[0]), 1);
        check("contend_beats", beat_cnt[0] + beat_cnt[1], 4);

        // preemption: ch1 arrives one cycle after ch0 (len 4)
        clr_counts();
        offer(2'b01, 4, 0, 1'b1);
        offer(2'b10, 0, 2, 1'b1);
        wait_done(1, 20);
        check("preempt_ch0_before", beat_cnt[0], 1);
        wait_idle(40);
        check("preempt_ch0_total", beat_cnt[0], 4);

        // zero length on ch1
        clr_counts();
        offer(2'b10, 0, 0, 1'b1);
        wait_done(1, 20);
        check("zero_len_beats", beat_cnt[1], 1);
        wait_idle(20);

        // no grant ever
        clr_counts();
        arb_off = 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
        offer(2'b01, 2, 0, 1'b0);
        begin
            int k = 1;
            while (!timeout_err[0] && k < 40) begin
                tick();
                k++;
            end
            check("timeout_cycle", k, TIMEOUT);
        end
        tick();
        check("timeout_request_drop", int'(request[0]), 0);
        arb_off = 1'b0;
        wait_idle(20);
        check("timeout_pulses", to_cnt[0], 1);
        check("timeout_no_done", done_cyc[0], 0);
`else
        offer(2'b01, 2, 0, 1'b1);
        repeat (20) tick();
        check("no_timeout_request_held", int'(request[0]), 1);
        check("no_timeout_err", to_cnt[0], 0);
        arb_off = 1'b0;
        wait_idle(20);
`endif

        // reset in the middle of a transfer
        clr_counts();
        offer(2'b01, 4, 0, 1'b1);
        tick();
        check("abort_first_beat", int'(beat[0]), 1);
        rst = 1'b1;
        exp_q[0].delete();
        tick();
        check("abort_rst_outputs", int'({request, beat, done, timeout_err}), 0);
        check("abort_rst_ready", int'(job_ready), 0);
        rst = 1'b0;
        tick();
        check("abort_post_request", int'(request), 0);
        check("abort_post_ready", int'(job_ready), 3);
        repeat (5) tick();
        check("abort_no_more_beats", beat_cnt[0], 1);
        check("abort_no_done", done_cyc[0], 0);

        check("sb_empty", exp_q[0].size() + exp_q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
